// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the modular-exponentiation sequencer:
//   state_t          - sequencer state encoding
//   OP_PRE..OP_POST  - operand-select codes driven to the Montgomery datapath
//   is_launch_state  - true for the states that launch a multiplication
// -----------------------------------------------------------------------------
package rsa_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_PRE_S  = 4'd1,
        ST_PRE_W  = 4'd2,
        ST_SQ_S   = 4'd3,
        ST_SQ_W   = 4'd4,
        ST_MUL_S  = 4'd5,
        ST_MUL_W  = 4'd6,
        ST_POST_S = 4'd7,
        ST_POST_W = 4'd8,
        ST_DONE   = 4'd9
    } state_t;

    // Operand selection for the shared multiplier
    localparam logic [1:0] OP_PRE  = 2'd0;  // M * R^2  -> M_bar
    localparam logic [1:0] OP_SQ   = 2'd1;  // R * R
    localparam logic [1:0] OP_MUL  = 2'd2;  // R * M_bar
    localparam logic [1:0] OP_POST = 2'd3;  // R * 1

    function automatic logic is_launch_state(input state_t st);
        return (st == ST_PRE_S) || (st == ST_SQ_S) ||
               (st == ST_MUL_S) || (st == ST_POST_S);
    endfunction

endpackage

// File: rtl/rsa_exp_ctrl.sv
// -----------------------------------------------------------------------------
// rsa_exp_ctrl
// Left-to-right square-and-multiply sequencer driving a shared Montgomery
// multiplier. One multiplication is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rstb       asynchronous active-low reset
//   en         global enable; 0 freezes all state and silences all pulses
//   start      request, only looked at in IDLE
//   exp_e      exponent, captured when start is accepted
//   mmm_done   multiplier completion pulse (only honoured in wait states)
//   mmm_start  one-cycle multiplier launch
//   op_sel     operand select (OP_PRE / OP_SQ / OP_MUL / OP_POST)
//   init_r     pulse: load R with the Montgomery one
//   ld_m       pulse: load M_bar from the multiplier result
//   ld_r       pulse: load R from the multiplier result
//   eoc        one-cycle end-of-conversion pulse
//   busy       high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module rsa_exp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] exp_e,
    input  logic             mmm_done,
    output logic             mmm_start,
    output logic [1:0]       op_sel,
    output logic             init_r,
    output logic             ld_m,
    output logic             ld_r,
    output logic             eoc,
    output logic             busy
);

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] exp_reg,   exp_next;
    logic [IDX_W-1:0] idx_reg,   idx_next;
    logic [1:0]       op_sel_reg, op_sel_next;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg  <= ST_IDLE;
            exp_reg    <= '0;
            idx_reg    <= '0;
            op_sel_reg <= OP_PRE;
        end else begin
            state_reg  <= state_next;
            exp_reg    <= exp_next;
            idx_reg    <= idx_next;
            op_sel_reg <= op_sel_next;
        end
    end

    // op_sel is registered and loaded on entry to each launch state, so it is
    // already valid in the launch cycle and naturally holds through the wait
    // state, DONE and the following IDLE.
    always_comb begin
        state_next  = state_reg;
        exp_next    = exp_reg;
        idx_next    = idx_reg;
        op_sel_next = op_sel_reg;
        init_r      = 1'b0;
        ld_m        = 1'b0;
        ld_r        = 1'b0;

        if (en) begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        exp_next    = exp_e;
                        idx_next    = IDX_TOP;
                        init_r      = 1'b1;
                        op_sel_next = OP_PRE;
                        state_next  = ST_PRE_S;
                    end
                end
                ST_PRE_S:  state_next = ST_PRE_W;
                ST_PRE_W: begin
                    if (mmm_done) begin
                        ld_m        = 1'b1;
                        op_sel_next = OP_SQ;
                        state_next  = ST_SQ_S;
                    end
                end
                ST_SQ_S:   state_next = ST_SQ_W;
                ST_SQ_W: begin
                    if (mmm_done) begin
                        ld_r = 1'b1;
                        if (exp_reg[idx_reg]) begin
                            // Multiply before moving on; idx is consumed in MUL_W
                            op_sel_next = OP_MUL;
                            state_next  = ST_MUL_S;
                        end else if (idx_reg == '0) begin
                            op_sel_next = OP_POST;
                            state_next  = ST_POST_S;
                        end else begin
                            idx_next    = idx_reg - 1'b1;
                            op_sel_next = OP_SQ;
                            state_next  = ST_SQ_S;
                        end
                    end
                end
                ST_MUL_S:  state_next = ST_MUL_W;
                ST_MUL_W: begin
                    if (mmm_done) begin
                        ld_r = 1'b1;
                        if (idx_reg == '0) begin
                            op_sel_next = OP_POST;
                            state_next  = ST_POST_S;
                        end else begin
                            idx_next    = idx_reg - 1'b1;
                            op_sel_next = OP_SQ;
                            state_next  = ST_SQ_S;
                        end
                    end
                end
                ST_POST_S: state_next = ST_POST_W;
                ST_POST_W: begin
                    if (mmm_done) begin
                        ld_r       = 1'b1;
                        state_next = ST_DONE;
                    end
                end
                ST_DONE:   state_next = ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // Launch and end-of-conversion pulses are pure state decodes, gated by en
    // so a stall never produces a pulse.
    assign mmm_start = en && is_launch_state(state_reg);
    assign eoc       = en && (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign op_sel    = op_sel_reg;

endmodule
